dtree_feature_loader: RTL and testbench

Front-end and back-end wrapper for the combinational printed decision-tree classifier. It accepts one sample as a byte stream over a valid/ready handshake and assembles the bytes into the parallel feature bus the tree consumes. It holds that bus stable for a programmable settle time, captures the tree's class output, and returns the class over a second valid/ready handshake. It sits between the serial sensor/host link and the tree instance.

---
 rtl/dtree_feature_loader.sv | 138 +++++++++++++
 tb/tb_dtree_feature_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_feature_loader.sv
// Byte-stream loader, settle timer and result capture for the
// printed decision tree. Ports: clk, rst_n (sync, active-low);
// byte input in_data/in_valid/in_ready; feature bus feat to the
// tree; class input cls_in; result output res_class/res_valid/
// res_ready; busy status. Optional res_tag sequence number under
// DTREE_LOADER_TAG_EN.
module dtree_feature_loader #(
  parameter int NFEAT  = 9,
  parameter int W      = 8,
  parameter int CW     = 2,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W-1:0]       in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [NFEAT*W-1:0] feat,
  input  logic [CW-1:0]      cls_in,
  output logic [CW-1:0]      res_class,
  output logic               res_valid,
  input  logic               res_ready,
`ifdef DTREE_LOADER_TAG_EN
  output logic [7:0]         res_tag,
`endif
  output logic               busy
);

  localparam int IW =
    (NFEAT > 1) ? $clog2(NFEAT) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(NFEAT - 1);
  localparam logic [3:0] CNT_INIT =
    4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SETTLE,
    ST_OUT
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [NFEAT*W-1:0]   feat_q, feat_d;
  logic [CW-1:0]        cls_q, cls_d;
  logic                 in_acc;

`ifdef DTREE_LOADER_TAG_EN
  logic [7:0]           tag_q, tag_d;
  logic [7:0]           rtag_q, rtag_d;
`endif

  // Ready is masked during reset so nothing is
  // accepted before the state is defined.
  assign in_ready  = rst_n &&
                     (state_q == ST_LOAD);
  assign in_acc    = in_valid && in_ready;
  assign res_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_LOAD) ||
                     (idx_q != '0);
  assign feat      = feat_q;
  assign res_class = cls_q;
`ifdef DTREE_LOADER_TAG_EN
  assign res_tag   = rtag_q;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    feat_d  = feat_q;
    cls_d   = cls_q;
`ifdef DTREE_LOADER_TAG_EN
    tag_d   = tag_q;
    rtag_d  = rtag_q;
`endif
    unique case (state_q)
      ST_LOAD: begin
        if (in_acc) begin
          feat_d[int'(idx_q)*W +: W] = in_data;
          if (idx_q == LAST) begin
            idx_d   = '0;
            cnt_d   = CNT_INIT;
            state_d = ST_SETTLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          cls_d   = cls_in;
`ifdef DTREE_LOADER_TAG_EN
          rtag_d  = tag_q;
`endif
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          state_d = ST_LOAD;
`ifdef DTREE_LOADER_TAG_EN
          tag_d   = tag_q + 8'd1;
`endif
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      cnt_q   <= 4'd0;
      feat_q  <= '0;
      cls_q   <= '0;
`ifdef DTREE_LOADER_TAG_EN
      tag_q   <= 8'd0;
      rtag_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      feat_q  <= feat_d;
      cls_q   <= cls_d;
`ifdef DTREE_LOADER_TAG_EN
      tag_q   <= tag_d;
      rtag_q  <= rtag_d;
`endif
    end
  end

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Scoreboard bench for dtree_feature_loader.
// Expected results queued at send, popped on handshake.
module tb_dtree_feature_loader;

  localparam int NF = 9;
  localparam int W  = 8;
  localparam int FW = NF * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] feat;
  logic [1:0]    cls_in;
  logic [1:0]    res_class;
  logic          res_valid;
  logic          res_ready;
  logic          busy;
`ifdef DTREE_LOADER_TAG_EN
  logic [7:0]    res_tag;
`endif

  logic          ovr_en;
  logic [1:0]    ovr;

  typedef struct {
    logic [1:0]    c;
    logic [FW-1:0] f;
    logic [7:0]    t;
  } exp_t;

  exp_t sb[$];
  logic [7:0] exp_tag;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dtree_feature_loader #(
    .NFEAT(NF), .W(W), .CW(2), .SETTLE(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .feat     (feat),
    .cls_in   (cls_in),
    .res_class(res_class),
    .res_valid(res_valid),
    .res_ready(res_ready),
`ifdef DTREE_LOADER_TAG_EN
    .res_tag  (res_tag),
`endif
    .busy     (busy)
  );

  function automatic logic [1:0] tree_f(
    input logic [FW-1:0] f
  );
    if (f[7:0] > f[15:8]) return f[17:16];
    return f[65:64] ^ f[33:32];
  endfunction

  assign cls_in = ovr_en ? ovr : tree_f(feat);

  task automatic chk(
    input string tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  // Handshake fires on the next edge when both are
  // high here; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_class", res_class, e.c);
        chk("res_feat", feat, e.f);
`ifdef DTREE_LOADER_TAG_EN
        chk("res_tag", res_tag, e.t);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 0, 1);
    tick();
  endtask

  task automatic send_sample(
    input logic [FW-1:0] f
  );
    for (int k = 0; k < NF; k++)
      send_byte(f[k*W +: W]);
  endtask

  task automatic push(
    input logic [1:0] c,
    input logic [FW-1:0] f
  );
    exp_t e;
    e.c = c;
    e.f = f;
    e.t = exp_tag;
    sb.push_back(e);
    exp_tag = exp_tag + 8'd1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  function automatic logic [FW-1:0] rnd_feat();
    logic [FW-1:0] f;
    for (int k = 0; k < NF; k++)
      f[k*W +: W] = 8'($urandom_range(0, 255));
    return f;
  endfunction

  initial begin
    logic [FW-1:0] f;
    logic [FW-1:0] fs;
    logic [1:0]    cs;
    int n;
    int ns;

    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    ovr_en    = 1'b1;
    ovr       = 2'b10;
    exp_tag   = 8'd0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_feat", feat, 0);
    chk("rst_class", res_class, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", in_ready, 1);

    // back-to-back, constant stub class 2
    f = 72'h090807060504030201;
    send_sample(f);
    in_valid = 1'b0;
    push(2'b10, f);
    chk("t1_feat", feat, f);
    chk("t1_ready_settle", in_ready, 0);
    chk("t1_busy", busy, 1);
    chk("t1_valid_T", res_valid, 0);
    tick();
    chk("t1_valid_T1", res_valid, 0);
    tick();
    chk("t1_valid_T2", res_valid, 1);
    chk("t1_class", res_class, 2);
    chk("t1_ready_out", in_ready, 0);
    tick();
    chk("t1_ready_after", in_ready, 1);
    chk("t1_valid_after", res_valid, 0);
    drain();

    // class sampled at end of settle
    ovr = 2'b01;
    f = rnd_feat();
    send_sample(f);
    in_valid = 1'b0;
    ovr = 2'b11;
    push(2'b11, f);
    drain();

    // backpressure with sender holding a byte
    ovr_en = 1'b0;
    res_ready = 1'b0;
    f = rnd_feat();
    send_sample(f);
    push(tree_f(f), f);
    in_data  = 8'h55;
    in_valid = 1'b1;
    n = 0;
    while (!res_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bp_valid_rise", res_valid, 1);
    cs = tree_f(f);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", res_valid, 1);
      chk("bp_class", res_class, cs);
      chk("bp_ready", in_ready, 0);
      chk("bp_feat", feat, f);
    end
    res_ready = 1'b1;
    in_valid  = 1'b0;
    drain();
    chk("bp_accept_first", res_valid, 0);
    chk("bp_ready_back", in_ready, 1);

    // reset mid-sample
    for (int k = 0; k < 4; k++)
      send_byte(8'h11 + 8'(k));
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mrst_feat", feat, 0);
    chk("mrst_valid", res_valid, 0);
    chk("mrst_class", res_class, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", in_ready, 0);
    rst_n = 1'b1;
    exp_tag = 8'd0;
    #1;
    chk("mrst_ready_back", in_ready, 1);
    f = {NF{8'hAA}};
    send_sample(f);
    in_valid = 1'b0;
    chk("mrst_feat_aa", feat, f);
    push(tree_f(f), f);
    drain();

    // gapped valid, stub class 2
    ovr_en = 1'b1;
    ovr = 2'b10;
    fs = feat;
    f = 72'h090807060504030201;
    chk("gap_busy_idle", busy, 0);
    for (int k = 0; k < NF; k++) begin
      send_byte(f[k*W +: W]);
      if (k == 0)
        chk("gap_feat_hold", feat,
            {fs[FW-1:W], 8'h01});
      chk("gap_busy_acc", busy, 1);
      in_valid = 1'b0;
      if (k == NF - 1) push(2'b10, f);
      tick();
      chk("gap_busy_gap", busy, 1);
    end
    chk("gap_feat", feat, f);
    drain();
    chk("gap_busy_done", busy, 0);

    // streaming run; tag wraps when enabled
    ovr_en = 1'b0;
`ifdef DTREE_LOADER_TAG_EN
    ns = 257 - int'(exp_tag);
`else
    ns = 12;
`endif
    for (int s = 0; s < ns; s++) begin
      f = rnd_feat();
      send_sample(f);
      in_valid = 1'b0;
      push(tree_f(f), f);
    end
    drain();
`ifdef DTREE_LOADER_TAG_EN
    chk("tag_wrap_count", exp_tag, 8'd1);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
